// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: address width, reset PC, opcode constants and fetch FSM states.
package fetch_stage_pkg;

  localparam int unsigned CPU_PC_W     = 16;
  localparam logic [15:0] CPU_RESET_PC = 16'h0000;
  localparam int unsigned PC_INC       = 2;

  localparam logic [3:0] OP_BEQ = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HALTED
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus between the fetch stage and instruction memory.
interface fetch_stage_if #(
  parameter int unsigned PC_W = 16
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ready;
  logic            rdata_valid;
  logic [15:0]     rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata_valid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata_valid,
    output rdata
  );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter flop: sequential advance by PC_INC or load of a redirect target.
module fetch_stage_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     PC_W     = CPU_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(CPU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus2
);

  // Wraps silently at the top of the address space.
  assign pc_plus2 = pc + PC_W'(PC_INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_en) begin
      pc <= redirect_pc;
    end else if (load_en) begin
      pc <= pc_plus2;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, a single-entry output register
// toward decode, redirect flush with stale-response drop, and fetch stop on HLT.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     PC_W     = CPU_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(CPU_RESET_PC),
  parameter logic [3:0]      HALT_OP  = OP_HLT
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_stage_if.master   imem,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_valid,
  output logic [15:0]     if_instr,
  output logic [PC_W-1:0] if_pc_plus2,
  output logic            halted
);

  fetch_state_e    state, state_next;
  logic [PC_W-1:0] pc, pc_plus2;
  logic            req, handshake, load, halt_hit;
  logic            drop, drop_next;

  fetch_stage_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus2    (pc_plus2)
  );

  assign imem.req  = req;
  assign imem.addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REQ;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req        = 1'b0;
    handshake  = 1'b0;
    load       = 1'b0;
    halt_hit   = 1'b0;
    drop_next  = drop;

    case (state)
      REQ: begin
        req       = rst_n && (!if_valid || !stall);
        handshake = req && imem.ready;
        if (handshake) state_next = WAIT;
      end
      WAIT: begin
        if (imem.rdata_valid) begin
          if (drop) begin
            drop_next  = 1'b0;
            state_next = REQ;
          end else begin
            load = 1'b1;
            if (opcode_of(imem.rdata) == HALT_OP) begin
              halt_hit   = 1'b1;
              state_next = HALTED;
            end else begin
              state_next = REQ;
            end
          end
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = REQ;
    endcase

    // A response arriving with the redirect is the outstanding one, so it is
    // discarded here and no drop is armed for it.
    if (redirect_en) begin
      load     = 1'b0;
      halt_hit = 1'b0;
      if (handshake || (state == WAIT && !imem.rdata_valid)) begin
        drop_next  = 1'b1;
        state_next = WAIT;
      end else begin
        drop_next  = 1'b0;
        state_next = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop        <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= 16'h0000;
      if_pc_plus2 <= '0;
      halted      <= 1'b0;
    end else begin
      drop <= drop_next;
      if (redirect_en) begin
        if_valid <= 1'b0;
        halted   <= 1'b0;
      end else begin
        if (load) begin
          if_valid    <= 1'b1;
          if_instr    <= imem.rdata;
          if_pc_plus2 <= pc_plus2;
        end else if (if_valid && !stall) begin
          if_valid <= 1'b0;
        end
        if (halt_hit) halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the expected stream is a program walk from the
// current start PC, restarted at each redirect target and ending at the first HLT.
module tb_fetch_stage;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pcPlus2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic        halted;

  fetch_stage_if #(.PC_W(16)) imem ();

  fetch_stage #(
    .PC_W     (16),
    .RESET_PC (16'h0000),
    .HALT_OP  (4'hF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc_plus2 (if_pc_plus2),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:32767];
  exp_t        expQ [$];
  logic [15:0] walkPc = 16'h0000;
  bit          walkDone = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          deliveries = 0;
  int          memLatFixed = 0;
  int          forceLat = 0;
  logic [15:0] forceWord = 16'h0000;
  int          resetEpoch = 0;
  logic [15:0] held;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic topUp();
    exp_t e;
    while (!walkDone && expQ.size() < 8) begin
      e.instr   = mem[walkPc[15:1]];
      e.pcPlus2 = walkPc + 16'd2;
      expQ.push_back(e);
      if (e.instr[15:12] == 4'hF) walkDone = 1'b1;
      walkPc = walkPc + 16'd2;
    end
  endtask

  task automatic restartWalk(input logic [15:0] target);
    expQ.delete();
    walkPc   = target;
    walkDone = 1'b0;
    topUp();
  endtask

  task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    stall       = st;
    redirect_en = rd;
    redirect_pc = rpc;
    imem.ready  = rdy;
    if (rd) restartWalk(rpc);
  endtask

  // kind 0: handshake, 1: request, 2: if_valid
  task automatic waitFor(input string name, input int kind);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      case (kind)
        0:       seen = imem.req && imem.ready;
        1:       seen = imem.req;
        default: seen = if_valid;
      endcase
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  // Instruction memory: one response per accepted request, latency 1..3 cycles.
  initial begin
    int          lat;
    int          epoch;
    logic [15:0] word;
    imem.rdata_valid = 1'b0;
    imem.rdata       = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && imem.req && imem.ready) begin
        epoch = resetEpoch;
        if (forceLat != 0) begin
          lat      = forceLat;
          word     = forceWord;
          forceLat = 0;
        end else begin
          lat  = (memLatFixed != 0) ? memLatFixed : int'($urandom_range(3, 1));
          word = mem[imem.addr[15:1]];
        end
        repeat (lat) @(posedge clk);
        #1;
        if (epoch == resetEpoch && rst_n) begin
          imem.rdata_valid = 1'b1;
          imem.rdata       = word;
          @(posedge clk);
          #1;
          imem.rdata_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: a word is delivered at the coming edge when valid, not stalled, not flushed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && !stall && !redirect_en) begin
        deliveries++;
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected delivery: got %h, expected none", if_instr);
        end else begin
          e = expQ.pop_front();
          checkOutput("if_instr", 32'(if_instr), 32'(e.instr));
          checkOutput("if_pc_plus2", 32'(if_pc_plus2), 32'(e.pcPlus2));
          checkOutput("halted on delivery", 32'(halted), 32'(e.instr[15:12] == 4'hF));
          topUp();
        end
      end
      if (rst_n && halted) checkOutput("req while halted", 32'(imem.req), 32'd0);
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    mem[1] = 16'h2345;
    for (int i = 2; i < 8; i++) mem[i] = 16'h3000 + 16'(i);
    mem[8]      = 16'hF000;
    mem[16'h20] = 16'h4444;
    mem[16'h7FFF] = 16'h1357;
    imem.ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset req", 32'(imem.req), 32'd0);
    checkOutput("reset if_valid", 32'(if_valid), 32'd0);
    checkOutput("reset if_instr", 32'(if_instr), 32'd0);
    checkOutput("reset if_pc_plus2", 32'(if_pc_plus2), 32'd0);
    checkOutput("reset halted", 32'(halted), 32'd0);

    memLatFixed = 1;
    @(posedge clk);
    #1;
    imem.ready = 1'b1;
    restartWalk(16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first req", 32'(imem.req), 32'd1);
    checkOutput("first addr", 32'(imem.addr), 32'h0000);
    repeat (2) @(negedge clk);
    checkOutput("second req", 32'(imem.req), 32'd1);
    checkOutput("second addr", 32'(imem.addr), 32'h0002);
    repeat (4) @(negedge clk);

    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    waitFor("valid under stall", 2);
    held = if_instr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("req under stall", 32'(imem.req), 32'd0);
      checkOutput("valid under stall", 32'(if_valid), 32'd1);
      checkOutput("instr under stall", 32'(if_instr), 32'(held));
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("req after stall release", 32'(imem.req), 32'd1);

    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    forceLat  = 3;
    forceWord = 16'hAAAA;
    waitFor("handshake before redirect", 0);
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    waitFor("req after redirect", 1);
    checkOutput("redirect addr", 32'(imem.addr), 32'h0040);

    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("halted set", 32'(halted), 32'd1);
    checkOutput("no req when halted", 32'(imem.req), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("halted cleared", 32'(halted), 32'd0);
    checkOutput("req after unhalt", 32'(imem.req), 32'd1);
    checkOutput("unhalt addr", 32'(imem.addr), 32'h0020);

    applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    repeat (10) @(negedge clk);

    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    forceLat  = 3;
    forceWord = 16'h5555;
    waitFor("handshake before reset", 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    resetEpoch++;
    #1;
    checkOutput("mid reset req", 32'(imem.req), 32'd0);
    checkOutput("mid reset if_valid", 32'(if_valid), 32'd0);
    checkOutput("mid reset if_instr", 32'(if_instr), 32'd0);
    checkOutput("mid reset if_pc_plus2", 32'(if_pc_plus2), 32'd0);
    checkOutput("mid reset halted", 32'(halted), 32'd0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    restartWalk(16'h0000);
    rst_n = 1'b1;
    #1;
    checkOutput("req after reset", 32'(imem.req), 32'd1);
    checkOutput("addr after reset", 32'(imem.addr), 32'h0000);

    memLatFixed = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        rd;
      logic [15:0] tgt;
      rd = ($urandom_range(99, 0) < 8);
      case ($urandom_range(3, 0))
        0:       tgt = 16'hFFFE;
        1:       tgt = 16'h0010;
        default: tgt = 16'($urandom) & 16'hFFFE;
      endcase
      applyStimulus($urandom_range(3, 0) == 0, rd, tgt, $urandom_range(3, 0) != 0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("enough deliveries", 32'(deliveries > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
